fsm_escribir_rtc: RTL
=====================

FSM_ESCRIBIR_RTC -- requirements
Module: fsm_escribir_rtc

Interface
REQ-001 Parameter T_STROBE, default 4: wr low-pulse width in clk cycles per bus phase, range 1..15.
REQ-002 Parameters ADDR_COM/SEG/MIN/HORA/DIA/MES/ANIO, defaults 8'hF0/21/22/23/24/25/26: RTC register addresses, written in that order.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 do_it_escribir  input  1  active-low start request (level).
REQ-006 ram_data_in  input  8  byte read from the time RAM; valid one cycle after r_ram_enable.
REQ-007 a_d, cs, rd, wr  output  1 each  RTC bus controls, active-low (a_d=0 address phase, 1 data phase).
REQ-008 bus_out  output  8  value driven onto the RTC multiplexed AD bus.
REQ-009 ram_to_rtc  output  1  1 = bus_out is driven (tristate enable); rtc_to_ram  output  1  constant 0.
REQ-010 ram_addr  output  3  RAM index of the byte being written: 0=com_cyt, 1=seg ... 6=anio.
REQ-011 r_ram_enable  output  1  one-cycle RAM read strobe; w_ram_enable  output  1  constant 0.
REQ-012 busy  output  1  sequence in progress; done  output  1  one-cycle completion pulse.

Function
REQ-013 States: IDLE, A_SETUP, A_STROBE, A_HOLD, A_GAP, D_SETUP, D_STROBE, D_HOLD, D_GAP, DONE, WAIT_REL.
REQ-014 IDLE: do_it_escribir sampled 0 -> A_SETUP next cycle with index=0; otherwise stay.
REQ-015 A_SETUP (1 cycle): a_d=0, cs=0, wr=1, bus_out=address[index], ram_to_rtc=1.
REQ-016 A_STROBE (T_STROBE cycles, counter-timed): as A_SETUP but wr=0.
REQ-017 A_HOLD (1 cycle): wr=1, cs=0, a_d=0, bus still driven; r_ram_enable=1, ram_addr=index.
REQ-018 A_GAP (1 cycle): cs=1, a_d=1, ram_to_rtc=0; ram_data_in captured into internal data register.
REQ-019 D_SETUP/D_STROBE/D_HOLD/D_GAP: same timing as address phase with a_d=1 and bus_out=captured data; no RAM strobe.
REQ-020 D_GAP: index<6 -> index+1, A_SETUP; index=6 -> DONE.
REQ-021 Per register 2*(T_STROBE+3) cycles (14 at default); full sequence 7*14=98 cycles from first A_SETUP to DONE.
REQ-022 DONE (1 cycle): done=1, bus idle -> WAIT_REL.
REQ-023 WAIT_REL: stay until do_it_escribir=1, then IDLE; a held-low request never restarts the sequence.
REQ-024 busy=1 in A_SETUP through D_GAP and DONE; 0 in IDLE and WAIT_REL.
REQ-025 rd=1 at all times; rd and wr never 0 together; wr=0 only while cs=0.
REQ-026 bus_out changes only when wr=1; ram_to_rtc=0 whenever cs=1.
REQ-027 do_it_escribir changes while busy are ignored.
REQ-028 Idle bus values (IDLE, DONE, WAIT_REL): a_d=cs=rd=wr=1, bus_out=8'h00, ram_to_rtc=0, r_ram_enable=0, ram_addr=0.
REQ-029 Strobe counter width 4 bits; counter reloads on every SETUP entry.

Reset
REQ-030 reset=1 at a clock edge forces IDLE, index=0, counter=0, data register=0 and all outputs to REQ-028 values with done=busy=0, including mid-transfer (wr released next edge, no partial-phase completion).
REQ-031 After reset release with do_it_escribir already 0, sequence starts from index 0 on the first non-reset cycle in IDLE.

Verification
REQ-032 Reset 100 ns, do_it_escribir 1->0 -> A_SETUP next cycle, bus_out=F0, a_d=0; 98 cycles later done=1 once.
REQ-033 RAM model returning 8'h30+index -> data phases drive 30,31..36 in order after addresses F0,21..26; wr low exactly 4 cycles each phase.
REQ-034 do_it_escribir held low 2500 ns -> exactly one done pulse; release then re-assert -> second full sequence.
REQ-035 reset asserted during D_STROBE of index 3 -> next edge wr=cs=1, busy=0, ram_to_rtc=0; new start begins at F0.
REQ-036 T_STROBE=1 -> per-register time 8 cycles, total 56; protocol assertions REQ-025/026 hold throughout all tests.

Source files
------------

// File: rtl/fsm_escribir_rtc.sv
// ============================================================================
//  Module   : fsm_escribir_rtc
//  Purpose  : Writes seven time bytes from RAM into an RTC over a multiplexed
//             address/data bus, one address phase plus one data phase per byte.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fsm_escribir_rtc #(
    parameter int          T_STROBE  = 4,
    parameter logic [7:0]  ADDR_COM  = 8'hF0,
    parameter logic [7:0]  ADDR_SEG  = 8'h21,
    parameter logic [7:0]  ADDR_MIN  = 8'h22,
    parameter logic [7:0]  ADDR_HORA = 8'h23,
    parameter logic [7:0]  ADDR_DIA  = 8'h24,
    parameter logic [7:0]  ADDR_MES  = 8'h25,
    parameter logic [7:0]  ADDR_ANIO = 8'h26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       do_it_escribir,
    input  logic [7:0] ram_data_in,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] bus_out,
    output logic       ram_to_rtc,
    output logic       rtc_to_ram,
    output logic [2:0] ram_addr,
    output logic       r_ram_enable,
    output logic       w_ram_enable,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_A_SETUP  = 4'd1,
        S_A_STROBE = 4'd2,
        S_A_HOLD   = 4'd3,
        S_A_GAP    = 4'd4,
        S_D_SETUP  = 4'd5,
        S_D_STROBE = 4'd6,
        S_D_HOLD   = 4'd7,
        S_D_GAP    = 4'd8,
        S_DONE     = 4'd9,
        S_WAIT_REL = 4'd10
    } state_t;

    localparam logic [3:0] c_strobe_load = 4'(T_STROBE - 1);
    localparam logic [2:0] c_last_index  = 3'd6;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [2:0] r_index;
    logic [7:0] r_data;
    logic       w_load_cnt;
    logic       w_dec_cnt;
    logic [7:0] w_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_index <= 3'd0;
            r_cnt   <= 4'd0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (w_load_cnt) begin
                r_cnt <= c_strobe_load;
            end else if (w_dec_cnt) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_IDLE) begin
                r_index <= 3'd0;
            end else if (r_state == S_D_GAP && r_index != c_last_index) begin
                r_index <= r_index + 3'd1;
            end
            // RAM data is valid in the cycle after the read strobe issued in A_HOLD
            if (r_state == S_A_GAP) begin
                r_data <= ram_data_in;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_cnt   = 1'b0;
        w_dec_cnt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!do_it_escribir) begin
                    w_state_next = S_A_SETUP;
                    w_load_cnt   = 1'b1;
                end
            end
            S_A_SETUP:  w_state_next = S_A_STROBE;
            S_A_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_A_HOLD;
                end else begin
                    w_dec_cnt = 1'b1;
                end
            end
            S_A_HOLD:   w_state_next = S_A_GAP;
            S_A_GAP: begin
                w_state_next = S_D_SETUP;
                w_load_cnt   = 1'b1;
            end
            S_D_SETUP:  w_state_next = S_D_STROBE;
            S_D_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_D_HOLD;
                end else begin
                    w_dec_cnt = 1'b1;
                end
            end
            S_D_HOLD:   w_state_next = S_D_GAP;
            S_D_GAP: begin
                if (r_index == c_last_index) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_A_SETUP;
                    w_load_cnt   = 1'b1;
                end
            end
            S_DONE:     w_state_next = S_WAIT_REL;
            S_WAIT_REL: begin
                if (do_it_escribir) begin
                    w_state_next = S_IDLE;
                end
            end
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_index)
            3'd0:    w_addr = ADDR_COM;
            3'd1:    w_addr = ADDR_SEG;
            3'd2:    w_addr = ADDR_MIN;
            3'd3:    w_addr = ADDR_HORA;
            3'd4:    w_addr = ADDR_DIA;
            3'd5:    w_addr = ADDR_MES;
            default: w_addr = ADDR_ANIO;
        endcase
    end

    assign rd           = 1'b1;
    assign rtc_to_ram   = 1'b0;
    assign w_ram_enable = 1'b0;

    always_comb begin
        a_d          = 1'b1;
        cs           = 1'b1;
        wr           = 1'b1;
        bus_out      = 8'h00;
        ram_to_rtc   = 1'b0;
        ram_addr     = 3'd0;
        r_ram_enable = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
                a_d        = 1'b0;
                cs         = 1'b0;
                wr         = (r_state != S_A_STROBE);
                bus_out    = w_addr;
                ram_to_rtc = 1'b1;
                if (r_state == S_A_HOLD) begin
                    r_ram_enable = 1'b1;
                    ram_addr     = r_index;
                end
            end
            S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
                cs         = 1'b0;
                wr         = (r_state != S_D_STROBE);
                bus_out    = r_data;
                ram_to_rtc = 1'b1;
            end
            S_A_GAP, S_D_GAP: begin
            end
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

`default_nettype wire
